// File: rtl/pipe_ctrl_pkg.sv
// Types and constants shared by the pipeline hazard controller and its helpers.
package pipe_ctrl_pkg;

    localparam int                   REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] XZR_IDX   = 5'd31;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: flags an ID source that matches a load
// destination in EX. XZR never creates a dependency.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rn_i,
    input  logic [REG_IDX_W-1:0] id_rm_i,
    input  logic                 id_uses_rn_i,
    input  logic                 id_uses_rm_i,
    input  logic [REG_IDX_W-1:0] ex_rd_i,
    input  logic                 ex_mem_read_i,
    output logic                 lu_o
);

    always_comb begin
        lu_o = ex_mem_read_i && (ex_rd_i != XZR_IDX) &&
               ((id_uses_rn_i && (id_rn_i == ex_rd_i)) ||
                (id_uses_rm_i && (id_rm_i == ex_rd_i)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use bubbles,
// taken-branch squashes and data-memory waits, plus stall and timeout status.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MAX_WAIT          = 64,
    parameter int CNT_W             = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [REG_IDX_W-1:0] id_rn_i,
    input  logic [REG_IDX_W-1:0] id_rm_i,
    input  logic                 id_uses_rn_i,
    input  logic                 id_uses_rm_i,
    input  logic [REG_IDX_W-1:0] ex_rd_i,
    input  logic                 ex_mem_read_i,
    input  logic                 ex_br_taken_i,
    input  logic                 mem_busy_i,
    output logic                 pc_en_o,
    output logic                 ifid_en_o,
    output logic                 idex_en_o,
    output logic                 exmem_en_o,
    output logic                 memwb_en_o,
    output logic                 ifid_flush_o,
    output logic                 idex_bubble_o,
    output logic [CNT_W-1:0]     stall_cycles_o,
    output logic                 mem_timeout_o
);

    localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [1:0]        LS_INIT   = 2'(LOAD_STALL_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    ctrl_state_e       state_q, state_d, eff_state;
    logic [1:0]        load_cnt_q, load_cnt_d;
    logic [1:0]        saved_load_cnt_q, saved_load_cnt_d;
    logic [1:0]        eff_cnt;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic              lu;
    logic              pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
    logic              ifid_flush_c, idex_bubble_c;

    load_use_detect u_lu (
        .id_rn_i       (id_rn_i),
        .id_rm_i       (id_rm_i),
        .id_uses_rn_i  (id_uses_rn_i),
        .id_uses_rm_i  (id_uses_rm_i),
        .ex_rd_i       (ex_rd_i),
        .ex_mem_read_i (ex_mem_read_i),
        .lu_o          (lu)
    );

    // Once memory is ready, MEM_WAIT behaves as the state it interrupted.
    // A non-zero saved count means that state was LOAD_STALL.
    always_comb begin
        eff_state = state_q;
        eff_cnt   = load_cnt_q;
        if (state_q == MEM_WAIT) begin
            eff_cnt = saved_load_cnt_q;
            if (saved_load_cnt_q != 2'd0) begin
                eff_state = LOAD_STALL;
            end else begin
                eff_state = RUN;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= RUN;
            load_cnt_q       <= '0;
            saved_load_cnt_q <= '0;
            wait_cnt_q       <= '0;
            stall_cycles_q   <= '0;
            mem_timeout_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            load_cnt_q       <= load_cnt_d;
            saved_load_cnt_q <= saved_load_cnt_d;
            wait_cnt_q       <= wait_cnt_d;
            stall_cycles_q   <= stall_cycles_d;
            mem_timeout_q    <= mem_timeout_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        load_cnt_d       = load_cnt_q;
        saved_load_cnt_d = saved_load_cnt_q;
        wait_cnt_d       = '0;
        mem_timeout_d    = mem_timeout_q;
        stall_cycles_d   = stall_cycles_q;
        if (!pc_en_c && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        if (mem_busy_i) begin
            state_d = MEM_WAIT;
            if (wait_cnt_q == WAIT_LAST) begin
                wait_cnt_d    = wait_cnt_q;
                mem_timeout_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
            if (state_q == LOAD_STALL) begin
                saved_load_cnt_d = load_cnt_q;
            end else if (state_q == RUN) begin
                saved_load_cnt_d = '0;
            end
        end else begin
            saved_load_cnt_d = '0;
            case (eff_state)
                LOAD_STALL: begin
                    if (eff_cnt <= 2'd1) begin
                        state_d    = RUN;
                        load_cnt_d = '0;
                    end else begin
                        state_d    = LOAD_STALL;
                        load_cnt_d = eff_cnt - 2'd1;
                    end
                end
                default: begin
                    state_d    = RUN;
                    load_cnt_d = '0;
                    if (!ex_br_taken_i && lu && (LS_INIT != 2'd0)) begin
                        state_d    = LOAD_STALL;
                        load_cnt_d = LS_INIT;
                    end
                end
            endcase
        end
    end

    always_comb begin
        pc_en_c       = 1'b1;
        ifid_en_c     = 1'b1;
        idex_en_c     = 1'b1;
        exmem_en_c    = 1'b1;
        memwb_en_c    = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;
        if (mem_busy_i) begin
            pc_en_c    = 1'b0;
            ifid_en_c  = 1'b0;
            idex_en_c  = 1'b0;
            exmem_en_c = 1'b0;
            memwb_en_c = 1'b0;
        end else if (eff_state == LOAD_STALL) begin
            pc_en_c       = 1'b0;
            ifid_en_c     = 1'b0;
            idex_bubble_c = 1'b1;
        end else if (ex_br_taken_i) begin
            ifid_flush_c  = 1'b1;
            idex_bubble_c = 1'b1;
        end else if (lu) begin
            pc_en_c       = 1'b0;
            ifid_en_c     = 1'b0;
            idex_bubble_c = 1'b1;
        end
    end

    // Nothing may write while reset is held, even between clock edges.
    assign pc_en_o        = pc_en_c && rst_ni;
    assign ifid_en_o      = ifid_en_c && rst_ni;
    assign idex_en_o      = idex_en_c && rst_ni;
    assign exmem_en_o     = exmem_en_c && rst_ni;
    assign memwb_en_o     = memwb_en_c && rst_ni;
    assign ifid_flush_o   = ifid_flush_c && rst_ni;
    assign idex_bubble_o  = idex_bubble_c && rst_ni;
    assign stall_cycles_o = stall_cycles_q;
    assign mem_timeout_o  = mem_timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (2- and 3-cycle load stalls) share
// stimulus and are checked every cycle against an "owed stall cycles" model.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rn, id_rm, ex_rd;
    logic       uses_rn, uses_rm, mem_read, br, busy;

    logic [1:0]  pc_en, ifid_en, idex_en, exmem_en, memwb_en, flush, bubble, tmo_o;
    logic [15:0] stl_o [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state per instance: owed load-stall cycles, busy run length,
    // sticky timeout and stall counter.
    int ns_cfg [2] = '{2, 3};
    int mw_cfg [2] = '{64, 5};
    int owed   [2];
    int brun   [2];
    int stl    [2];
    bit tmo    [2];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(2), .MAX_WAIT(64), .CNT_W(16)) dut2 (
        .clk_i(clk), .rst_ni(rst_n),
        .id_rn_i(id_rn), .id_rm_i(id_rm), .id_uses_rn_i(uses_rn), .id_uses_rm_i(uses_rm),
        .ex_rd_i(ex_rd), .ex_mem_read_i(mem_read), .ex_br_taken_i(br), .mem_busy_i(busy),
        .pc_en_o(pc_en[0]), .ifid_en_o(ifid_en[0]), .idex_en_o(idex_en[0]),
        .exmem_en_o(exmem_en[0]), .memwb_en_o(memwb_en[0]),
        .ifid_flush_o(flush[0]), .idex_bubble_o(bubble[0]),
        .stall_cycles_o(stl_o[0]), .mem_timeout_o(tmo_o[0])
    );

    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MAX_WAIT(5), .CNT_W(16)) dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .id_rn_i(id_rn), .id_rm_i(id_rm), .id_uses_rn_i(uses_rn), .id_uses_rm_i(uses_rm),
        .ex_rd_i(ex_rd), .ex_mem_read_i(mem_read), .ex_br_taken_i(br), .mem_busy_i(busy),
        .pc_en_o(pc_en[1]), .ifid_en_o(ifid_en[1]), .idex_en_o(idex_en[1]),
        .exmem_en_o(exmem_en[1]), .memwb_en_o(memwb_en[1]),
        .ifid_flush_o(flush[1]), .idex_bubble_o(bubble[1]),
        .stall_cycles_o(stl_o[1]), .mem_timeout_o(tmo_o[1])
    );

    function automatic bit lu_ref();
        return mem_read && (ex_rd != 5'd31) &&
               ((uses_rn && (id_rn == ex_rd)) || (uses_rm && (id_rm == ex_rd)));
    endfunction

    // Expected {pc, ifid, idex, exmem, memwb, flush, bubble}.
    function automatic logic [6:0] exp_ctl(int k);
        if (!rst_n)     return 7'b0000000;
        if (busy)       return 7'b0000000;
        if (owed[k] > 0) return 7'b0011101;
        if (br)         return 7'b1111111;
        if (lu_ref())   return 7'b0011101;
        return 7'b1111100;
    endfunction

    function automatic logic [6:0] obs_ctl(int k);
        return {pc_en[k], ifid_en[k], idex_en[k], exmem_en[k], memwb_en[k], flush[k], bubble[k]};
    endfunction

    function automatic logic [4:0] pick();
        int r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            owed[k] = 0; brun[k] = 0; stl[k] = 0; tmo[k] = 1'b0;
        end
    endtask

    task automatic model_tick();
        logic [6:0] c;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                owed[k] = 0; brun[k] = 0; stl[k] = 0; tmo[k] = 1'b0;
            end else begin
                c = exp_ctl(k);
                if (!c[6] && stl[k] < 65535) stl[k]++;
                if (busy) begin
                    brun[k]++;
                    if (brun[k] >= mw_cfg[k]) tmo[k] = 1'b1;
                end else begin
                    brun[k] = 0;
                    if (owed[k] > 0) owed[k]--;
                    else if (!br && lu_ref()) owed[k] = ns_cfg[k] - 1;
                end
            end
        end
    endtask

    task automatic check_all(string tag);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            assert (obs_ctl(k) === exp_ctl(k)) else begin
                n_bad++;
                $error("FAIL %s dut%0d ctl observed=%b expected=%b", tag, k, obs_ctl(k), exp_ctl(k));
            end
            n_cmp++;
            assert (stl_o[k] === 16'(stl[k])) else begin
                n_bad++;
                $error("FAIL %s dut%0d stall_cycles observed=%0d expected=%0d", tag, k, stl_o[k], stl[k]);
            end
            n_cmp++;
            assert (tmo_o[k] === tmo[k]) else begin
                n_bad++;
                $error("FAIL %s dut%0d mem_timeout observed=%b expected=%b", tag, k, tmo_o[k], tmo[k]);
            end
        end
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic cycle(string tag);
        #1;
        check_all(tag);
        model_tick();
        @(negedge clk);
    endtask

    task automatic clear_in();
        id_rn = 5'd0; id_rm = 5'd0; ex_rd = 5'd0;
        uses_rn = 1'b0; uses_rm = 1'b0; mem_read = 1'b0; br = 1'b0; busy = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_in();
        model_reset();
        @(negedge clk);
        cycle("reset_hold");
        cycle("reset_hold");
        rst_n = 1'b1;
        cycle("post_reset");

        // Load X3 in EX, ID reads X3 via rn.
        mem_read = 1'b1; ex_rd = 5'd3; id_rn = 5'd3; uses_rn = 1'b1;
        cycle("lu_x3");
        clear_in();
        cycle("lu_x3_s2");
        cycle("lu_x3_s3");
        cycle("lu_x3_s4");
        n_cmp++;
        assert (stl_o[0] === 16'd2) else begin
            n_bad++;
            $error("FAIL lu_cost2 observed=%0d expected=2", stl_o[0]);
        end
        n_cmp++;
        assert (stl_o[1] === 16'd3) else begin
            n_bad++;
            $error("FAIL lu_cost3 observed=%0d expected=3", stl_o[1]);
        end

        // XZR never hazards.
        mem_read = 1'b1; ex_rd = 5'd31; id_rn = 5'd31; id_rm = 5'd31;
        uses_rn = 1'b1; uses_rm = 1'b1;
        cycle("xzr");
        clear_in();
        cycle("xzr_after");

        // Taken branch wins over a simultaneous load-use.
        mem_read = 1'b1; ex_rd = 5'd5; id_rm = 5'd5; uses_rm = 1'b1; br = 1'b1;
        cycle("br_lu");
        clear_in();
        cycle("br_after");
        cycle("br_after2");

        // Memory wait interrupting the 2nd load-stall cycle.
        mem_read = 1'b1; ex_rd = 5'd7; id_rm = 5'd7; uses_rm = 1'b1;
        cycle("lu_x7");
        clear_in();
        busy = 1'b1;
        for (int i = 0; i < 3; i++) cycle("ls_busy");
        busy = 1'b0;
        for (int i = 0; i < 4; i++) cycle("ls_resume");

        // Long memory wait to timeout; timeout must stay sticky.
        busy = 1'b1;
        for (int i = 0; i < 64; i++) cycle("busy64");
        busy = 1'b0;
        for (int i = 0; i < 3; i++) cycle("tmo_sticky");
        busy = 1'b1;
        cycle("busy_again");
        cycle("busy_again");

        // Asynchronous reset in the middle of MEM_WAIT.
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        @(negedge clk);
        cycle("rst_hold");
        rst_n = 1'b1;
        busy = 1'b0;
        cycle("rst_release");

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            ex_rd    = pick();
            id_rn    = pick();
            id_rm    = pick();
            uses_rn  = 1'($urandom_range(0, 1));
            uses_rm  = 1'($urandom_range(0, 1));
            mem_read = ($urandom_range(0, 99) < 50);
            br       = ($urandom_range(0, 99) < 15);
            busy     = ($urandom_range(0, 99) < 12);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage ARM pipeline. Drives the write enables of the enable-gated pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) and the squash controls that force bubbles. It handles load-use hazards, taken-branch squashes and multi-cycle data-memory waits. It sits beside the datapath, takes register indices and status from ID/EX/MEM, and keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

## Interface
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1 with MEM→EX forwarding, 2 without); legal range 1..3
- MAX_WAIT, 64, consecutive mem_busy cycles before mem_timeout sets
- CNT_W, 16, width of stall_cycles
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- id_rn, id_rm  in  5 each  source register indices of the instruction in ID
- id_uses_rn, id_uses_rm  in  1 each  source actually read
- ex_rd  in  5  destination of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_br_taken  in  1  branch in EX resolved taken
- mem_busy  in  1  data memory not ready this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register write enables
- ifid_flush  out  1  IF/ID loads NOP
- idex_bubble  out  1  ID/EX loads NOP (control bits zero)
- stall_cycles  out  CNT_W  cycles with pc_en=0, saturating at all-ones
- mem_timeout  out  1  sticky error

## Operation
- States: RUN, LOAD_STALL, MEM_WAIT. Registered: state, load_cnt (2 b), saved_load_cnt, wait_cnt, stall_cycles, mem_timeout.
- Hazard: lu = ex_mem_read & ex_rd≠31 & ((id_uses_rn & id_rn==ex_rd) | (id_uses_rm & id_rm==ex_rd)). Register 31 (XZR) never hazards.
- Event priority, highest first: mem_busy, ex_br_taken, lu.
- RUN, no event: all enables 1, flush/bubble 0.
- RUN, ex_br_taken: pc_en=1 (loads target), ifid_flush=1, idex_bubble=1, all other enables 1. Any lu in the same cycle is ignored. Stay RUN.
- RUN, lu: pc_en=ifid_en=0, idex_bubble=1, idex_en/exmem_en/memwb_en=1. If LOAD_STALL_CYCLES>1, go to LOAD_STALL with load_cnt=LOAD_STALL_CYCLES-1. Otherwise stay RUN.
- LOAD_STALL: same outputs as the lu cycle. load_cnt decrements; at 1, go to RUN. ex_br_taken is ignored here because EX holds a bubble.
- mem_busy in any state: every *_en=0, flush/bubble 0. Go to MEM_WAIT. load_cnt is saved when leaving LOAD_STALL.
- MEM_WAIT: outputs as above. wait_cnt increments, saturating. When wait_cnt reaches MAX_WAIT-1 while mem_busy, mem_timeout sets and stays set until reset. When mem_busy drops: return to LOAD_STALL with the saved count if entered from there, else RUN. Outputs in the return cycle follow that state's rules (Mealy on inputs). wait_cnt clears.
- stall_cycles increments on every cycle with pc_en=0 and saturates at 2^CNT_W-1.
- While reset is low: state=RUN, all counters 0, mem_timeout=0, every *_en=0, ifid_flush=0, idex_bubble=0. Outputs are gated by reset so nothing writes during reset.

## Timing
- Outputs are combinational from state and current inputs: zero-cycle latency from hazard input to enable.
- Load-use costs exactly LOAD_STALL_CYCLES cycles, excluding memory waits. Taken branch costs 2 squashed slots in 1 cycle.
- Reset assertion mid-stall aborts immediately (asynchronous). The first cycle after deassertion is RUN.
- mem_timeout rises on the clock edge ending the MAX_WAIT-th consecutive busy cycle.

## Structure
- Package pipe_ctrl_pkg holds: state enum (RUN, LOAD_STALL, MEM_WAIT), REG_IDX_W=5, XZR_IDX=5'd31.
- Sub-module load_use_detect: purely combinational lu equation, reused by the forwarding-unit bench.
- The top holds the FSM, counters and output decode.

## Test plan
- Load X3 in EX, ID reads X3 via rn, LOAD_STALL_CYCLES=2 -> pc_en=ifid_en=0 and idex_bubble=1 for exactly 2 cycles, then all enables 1; stall_cycles=2.
- Load to X31 in EX, ID reads X31 -> no stall, all enables 1.
- ex_br_taken and lu in the same cycle -> ifid_flush=idex_bubble=1, pc_en=1, no stall follows.
- mem_busy for 3 cycles during the 2nd LOAD_STALL cycle (LOAD_STALL_CYCLES=3) -> enables all 0 for 3 cycles, then 2 remaining load-stall cycles, then RUN.
- mem_busy held 64 cycles (MAX_WAIT=64) -> mem_timeout=1 after cycle 64; stays 1 after busy drops; cleared only by reset.
- Assert reset mid MEM_WAIT -> all outputs 0 immediately; after release state RUN, stall_cycles=0, enables 1.
